// File: rtl/picosoc_arb_pkg.sv
// Shared types and constants for the two-master picorv32 memory-bus arbiter.
// Used by picosoc_mem_arbiter and picosoc_rr_pick.
package picosoc_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StG0   = 2'd1,
    StG1   = 2'd2
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/picosoc_mem_arbiter_if.sv
// picorv32-native memory bus (valid/ready handshake) with requester and responder views.
interface picosoc_mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/picosoc_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie, the requester that was not last served wins.
module picosoc_rr_pick
  import picosoc_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = GRANT_NONE;
    case (req)
      2'b01:   pick = GRANT_M0;
      2'b10:   pick = GRANT_M1;
      2'b11:   pick = last ? GRANT_M0 : GRANT_M1;
      default: pick = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 memory bus between two masters, grant locked per transfer.
// Optional slave-response watchdog enabled by defining ARB_TIMEOUT_EN.
module picosoc_mem_arbiter
  import picosoc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RESET_PRIO     = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  picosoc_mem_arbiter_if.slave    m0,
  picosoc_mem_arbiter_if.slave    m1,
  picosoc_mem_arbiter_if.master   s,
  output logic [1:0]              grant,
  output logic                    err
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] pick;
  logic       own_valid;
  logic       timeout;
  logic       done;

  picosoc_rr_pick u_pick (
    .req  ({m1.valid, m0.valid}),
    .last (last_q),
    .pick (pick)
  );

  assign own_valid = (state_q == StG0) ? m0.valid :
                     (state_q == StG1) ? m1.valid : 1'b0;

  // A real slave response wins over a watchdog expiry in the same cycle.
  assign done = own_valid && (s.ready || timeout);

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q;
  logic        err_q;

  assign timeout = own_valid && !s.ready && (cnt_q == TimeoutLimit);

  // Every grant is entered from idle, so clearing in idle clears on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == StIdle) ? '0 : cnt_q + 16'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign m0.rdata = timeout ? ARB_ERR_DATA : s.rdata;
  assign m1.rdata = timeout ? ARB_ERR_DATA : s.rdata;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant    = GRANT_NONE;
    s.valid  = 1'b0;
    s.instr  = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.wstrb  = '0;
    m0.ready = 1'b0;
    m1.ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick == GRANT_M0)      state_d = StG0;
        else if (pick == GRANT_M1) state_d = StG1;
      end
      StG0: begin
        grant    = GRANT_M0;
        s.valid  = m0.valid;
        s.instr  = m0.instr;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        s.wstrb  = m0.wstrb;
        m0.ready = done;
        if (!m0.valid) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StG1: begin
        grant    = GRANT_M1;
        s.valid  = m1.valid;
        s.instr  = m1.instr;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        s.wstrb  = m1.wstrb;
        m1.ready = done;
        if (!m1.valid) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      last_q  <= RESET_PRIO[0];
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
